// File: rtl/lock_controller_if.sv
// Keypad/checker-facing signal bundle for lock_controller; master is the controller side.
interface lock_controller_if;
  logic       bstate;
  logic [3:0] button;
  logic       correct;
  logic       dataready;
  logic [1:0] compareType;
  logic       readInput;
  logic       store;
  logic       unlocked;
  logic       alarm;
  logic [1:0] fail_count;
  logic [2:0] state;

  modport master (
    input  bstate, button, correct, dataready,
    output compareType, readInput, store, unlocked, alarm, fail_count, state
  );

  modport slave (
    output bstate, button, correct, dataready,
    input  compareType, readInput, store, unlocked, alarm, fail_count, state
  );
endinterface

// File: rtl/lock_controller.sv
// Keypad lock FSM: code check, code change with confirm, fail counting and alarm.
// Optional auto-relock of OPEN is enabled by defining LOCK_AUTO_RELOCK_EN.
module lock_controller #(
  parameter int SETTLE_CYCLES = 4,
  parameter int RELOCK_CYCLES = 12000000,
  parameter int MAX_FAILS     = 3
) (
  input logic              hwclk,
  input logic              rst,
  lock_controller_if.master bus
);

  typedef enum logic [2:0] {
    LOCKED     = 3'd0,
    CHECK      = 3'd1,
    OPEN       = 3'd2,
    NEW_CODE   = 3'd3,
    CHECK_NEW  = 3'd4,
    CONFIRM    = 3'd5,
    CHECK_CONF = 3'd6,
    ALARM      = 3'd7
  } state_e;

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [3:0] KEY_ENTER = 4'd8;
  localparam logic [3:0] KEY_MODE  = 4'd9;
  localparam logic [3:0] KEY_CLEAR = 4'd7;

  logic          sync1_q, sync2_q, sync3_q;
  logic [3:0]    key_q;
  state_e        state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [1:0]    fails_q, fails_d;
  logic [1:0]    store_cnt_q, store_cnt_d;
  logic          alarm_wait_q, alarm_wait_d;

  logic [1:0]    ct_q, ct_d;
  logic          ri_q, ri_d;
  logic          store_q, store_d;
  logic          unl_q, unl_d;
  logic          alm_q, alm_d;
  logic [1:0]    fc_q;
  logic [2:0]    st_q;

  logic          key_rel;
  logic          key_enter, key_mode, key_clear;
  logic          settle_done;
  logic [1:0]    fail_next;
  logic          relock_done;
  logic          unused_dataready;

  assign unused_dataready = bus.dataready;

  always_ff @(posedge hwclk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      key_q   <= 4'd0;
    end else begin
      sync1_q <= bus.bstate;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      if (sync2_q) key_q <= bus.button;
    end
  end

  assign key_rel     = sync3_q & ~sync2_q;
  assign key_enter   = key_rel && (key_q == KEY_ENTER);
  assign key_mode    = key_rel && (key_q == KEY_MODE);
  assign key_clear   = key_rel && (key_q == KEY_CLEAR);
  assign settle_done = (settle_q == SW'(SETTLE_CYCLES - 1));
  assign fail_next   = (fails_q == 2'(MAX_FAILS)) ? fails_q : fails_q + 2'd1;

`ifdef LOCK_AUTO_RELOCK_EN
  localparam int RW = $clog2(RELOCK_CYCLES + 1);
  logic [RW-1:0] relock_q, relock_d;

  // Held at zero outside OPEN, so every entry into OPEN starts a fresh timeout.
  always_comb begin
    relock_d = relock_q + RW'(1);
    if (state_q != OPEN) relock_d = '0;
  end

  assign relock_done = (state_q == OPEN) && (relock_q == RW'(RELOCK_CYCLES - 1));

  always_ff @(posedge hwclk) begin
    if (rst) relock_q <= '0;
    else     relock_q <= relock_d;
  end
`else
  logic unused_relock;
  assign unused_relock = (RELOCK_CYCLES > 0);
  assign relock_done   = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    settle_d     = settle_q;
    fails_d      = fails_q;
    store_cnt_d  = store_cnt_q;
    alarm_wait_d = alarm_wait_q;
    case (state_q)
      LOCKED: begin
        if (key_enter) begin
          state_d  = CHECK;
          settle_d = '0;
        end
      end
      CHECK: begin
        settle_d = settle_q + SW'(1);
        if (settle_done) begin
          if (bus.correct) begin
            state_d = OPEN;
            fails_d = 2'd0;
          end else begin
            fails_d = fail_next;
            state_d = (fail_next == 2'(MAX_FAILS)) ? ALARM : LOCKED;
          end
        end
      end
      OPEN: begin
        if (relock_done)    state_d = LOCKED;
        else if (key_mode)  state_d = NEW_CODE;
        else if (key_clear) state_d = LOCKED;
      end
      NEW_CODE: begin
        if (key_enter) begin
          state_d  = CHECK_NEW;
          settle_d = '0;
        end else if (key_mode) begin
          state_d = OPEN;
        end
      end
      CHECK_NEW: begin
        settle_d = settle_q + SW'(1);
        if (settle_done) state_d = bus.correct ? CONFIRM : OPEN;
      end
      CONFIRM: begin
        if (key_enter) begin
          state_d     = CHECK_CONF;
          settle_d    = '0;
          store_cnt_d = 2'd0;
        end else if (key_mode) begin
          state_d = OPEN;
        end
      end
      CHECK_CONF: begin
        // After a successful confirm, store_cnt_q paces the two-cycle commit pulse.
        if (store_cnt_q != 2'd0) begin
          store_cnt_d = store_cnt_q - 2'd1;
          if (store_cnt_q == 2'd1) state_d = LOCKED;
        end else begin
          settle_d = settle_q + SW'(1);
          if (settle_done) begin
            if (bus.correct) store_cnt_d = 2'd2;
            else             state_d     = OPEN;
          end
        end
      end
      ALARM: begin
        if (alarm_wait_q) begin
          settle_d = settle_q + SW'(1);
          if (settle_done) begin
            alarm_wait_d = 1'b0;
            if (bus.correct) begin
              state_d = LOCKED;
              fails_d = 2'd0;
            end
          end
        end else if (key_enter) begin
          alarm_wait_d = 1'b1;
          settle_d     = '0;
        end
      end
      default: state_d = LOCKED;
    endcase
  end

  always_comb begin
    ct_d    = 2'b01;
    ri_d    = 1'b1;
    store_d = 1'b0;
    unl_d   = (state_q == OPEN);
    alm_d   = (state_q == ALARM);
    case (state_q)
      NEW_CODE, CHECK_NEW:  ct_d = 2'b11;
      CONFIRM, CHECK_CONF:  ct_d = 2'b10;
      ALARM:                ct_d = 2'b00;
      default:              ct_d = 2'b01;
    endcase
    if (state_q == CHECK || state_q == CHECK_NEW || state_q == CHECK_CONF) ri_d = 1'b0;
    if (state_q == CHECK_CONF && store_cnt_q != 2'd0) store_d = 1'b1;
  end

  always_ff @(posedge hwclk) begin
    if (rst) begin
      state_q      <= LOCKED;
      settle_q     <= '0;
      fails_q      <= 2'd0;
      store_cnt_q  <= 2'd0;
      alarm_wait_q <= 1'b0;
      ct_q         <= 2'b01;
      ri_q         <= 1'b1;
      store_q      <= 1'b0;
      unl_q        <= 1'b0;
      alm_q        <= 1'b0;
      fc_q         <= 2'd0;
      st_q         <= 3'd0;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      fails_q      <= fails_d;
      store_cnt_q  <= store_cnt_d;
      alarm_wait_q <= alarm_wait_d;
      ct_q         <= ct_d;
      ri_q         <= ri_d;
      store_q      <= store_d;
      unl_q        <= unl_d;
      alm_q        <= alm_d;
      fc_q         <= fails_q;
      st_q         <= state_q;
    end
  end

  assign bus.compareType = ct_q;
  assign bus.readInput   = ri_q;
  assign bus.store       = store_q;
  assign bus.unlocked    = unl_q;
  assign bus.alarm       = alm_q;
  assign bus.fail_count  = fc_q;
  assign bus.state       = st_q;

endmodule

// File: tb/tb_lock_controller.sv
// Scoreboard bench for lock_controller: every change of the output tuple is matched against a queue.
// Define LOCK_AUTO_RELOCK_EN for both bench and RTL to exercise the relock timeout.
module tb_lock_controller;

`ifdef LOCK_AUTO_RELOCK_EN
  localparam int RELOCK = 20;
`else
  localparam int RELOCK = 12000000;
`endif

  logic hwclk = 1'b0;
  logic rst;

  lock_controller_if bus ();

  lock_controller #(
    .SETTLE_CYCLES(4),
    .RELOCK_CYCLES(RELOCK),
    .MAX_FAILS    (3)
  ) dut (
    .hwclk(hwclk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 hwclk = ~hwclk;

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] ct;
    logic       ri;
    logic       sto;
    logic       unl;
    logic       alm;
    logic [1:0] fc;
  } obs_t;

  typedef struct {
    obs_t  o;
    int    dur;
    string name;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic obs_t mk(input int st, input int ct, input bit ri, input bit sto,
                              input bit unl, input bit alm, input int fc);
    obs_t o;
    o.st  = 3'(st);
    o.ct  = 2'(ct);
    o.ri  = ri;
    o.sto = sto;
    o.unl = unl;
    o.alm = alm;
    o.fc  = 2'(fc);
    return o;
  endfunction

  task automatic push(input obs_t o, input int dur, input string name);
    exp_t e;
    e.o    = o;
    e.dur  = dur;
    e.name = name;
    q.push_back(e);
  endtask

  // Monitor: any change of the observed outputs consumes one expectation.
  initial begin
    obs_t cur;
    obs_t prev;
    exp_t e;
    int   dur;
    prev = 'x;
    dur  = 0;
    forever begin
      @(negedge hwclk);
      cur = {bus.state, bus.compareType, bus.readInput, bus.store,
             bus.unlocked, bus.alarm, bus.fail_count};
      if (cur !== prev) begin
        n_chk++;
        if (q.size() == 0) begin
          $display("FAIL unexpected_change: got=%h want=no change (prev=%h)", cur, prev);
        end else begin
          e = q.pop_front();
          if (cur === e.o) n_pass++;
          else $display("FAIL %s: got=%h want=%h", e.name, cur, e.o);
          if (e.dur != 0) begin
            n_chk++;
            if (dur == e.dur) n_pass++;
            else $display("FAIL %s_prev_duration: got=%0d cycles want=%0d", e.name, dur, e.dur);
          end
        end
        prev = cur;
        dur  = 1;
      end else begin
        dur++;
      end
    end
  end

  task automatic press(input logic [3:0] k);
    bus.button = k;
    bus.bstate = 1'b1;
    repeat (3) @(posedge hwclk);
    #1 bus.bstate = 1'b0;
  endtask

  task automatic settle_idle(input int extra);
    int cnt;
    cnt = 0;
    while (q.size() != 0 && cnt < 100) begin
      @(posedge hwclk);
      #1 cnt++;
    end
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL drain_timeout: got=%0d pending want=0", q.size());
      q.delete();
    end
    repeat (extra) @(posedge hwclk);
    #1;
  endtask

  task automatic key(input logic [3:0] k, input logic corr);
    bus.correct = corr;
    press(k);
    settle_idle(4);
  endtask

  localparam obs_t S_LOCKED   = 11'b000_01_1_0_0_0_00;

  task automatic do_unlock();
    push(mk(1, 1, 0, 0, 0, 0, 0), 0, "check");
    push(mk(2, 1, 1, 0, 1, 0, 0), 4, "open");
    key(4'd8, 1'b1);
  endtask

  task automatic to_confirm();
    push(mk(3, 3, 1, 0, 0, 0, 0), 0, "new_code");
    key(4'd9, 1'b1);
    push(mk(4, 3, 0, 0, 0, 0, 0), 0, "check_new");
    push(mk(5, 2, 1, 0, 0, 0, 0), 4, "confirm");
    key(4'd8, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got=timeout want=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int cnt;
    rst           = 1'b1;
    bus.bstate    = 1'b0;
    bus.button    = 4'd0;
    bus.correct   = 1'b0;
    bus.dataready = 1'b0;
    push(S_LOCKED, 0, "reset");
    repeat (3) @(posedge hwclk);
    #1 rst = 1'b0;
    settle_idle(4);

    // Unlock on first try, then lock with key 7
    do_unlock();
    push(S_LOCKED, 0, "lock_key7");
    key(4'd7, 1'b0);

    // Three failures into ALARM, ignored keys, recovery
    key(4'd9, 1'b0);
    push(mk(1, 1, 0, 0, 0, 0, 0), 0, "check_f0");
    push(mk(0, 1, 1, 0, 0, 0, 1), 4, "fail1");
    key(4'd8, 1'b0);
    push(mk(1, 1, 0, 0, 0, 0, 1), 0, "check_f1");
    push(mk(0, 1, 1, 0, 0, 0, 2), 4, "fail2");
    key(4'd8, 1'b0);
    push(mk(1, 1, 0, 0, 0, 0, 2), 0, "check_f2");
    push(mk(7, 0, 1, 0, 0, 1, 3), 4, "alarm");
    key(4'd8, 1'b0);
    key(4'd5, 1'b0);
    bus.correct = 1'b0;
    press(4'd8);
    settle_idle(12);
    push(S_LOCKED, 0, "alarm_clear");
    key(4'd8, 1'b1);

    // Code change: NEW_CODE, CONFIRM, CHECK_CONF, two-cycle store, LOCKED
    do_unlock();
    to_confirm();
    push(mk(6, 2, 0, 0, 0, 0, 0), 0, "check_conf");
    push(mk(6, 2, 0, 1, 0, 0, 0), 4, "store_on");
    push(S_LOCKED, 2, "store_done");
    key(4'd8, 1'b1);

    // Confirm mismatch, abort from NEW_CODE, and CHECK_NEW mismatch all return to OPEN
    do_unlock();
    to_confirm();
    push(mk(6, 2, 0, 0, 0, 0, 0), 0, "check_conf_bad");
    push(mk(2, 1, 1, 0, 1, 0, 0), 4, "conf_bad_open");
    key(4'd8, 1'b0);
    push(mk(3, 3, 1, 0, 0, 0, 0), 0, "new_code2");
    key(4'd9, 1'b0);
    push(mk(2, 1, 1, 0, 1, 0, 0), 0, "abort_open");
    key(4'd9, 1'b0);
    push(mk(3, 3, 1, 0, 0, 0, 0), 0, "new_code3");
    key(4'd9, 1'b0);
    push(mk(4, 3, 0, 0, 0, 0, 0), 0, "check_new_bad");
    push(mk(2, 1, 1, 0, 1, 0, 0), 4, "new_bad_open");
    key(4'd8, 1'b0);
    push(S_LOCKED, 0, "lock_key7_b");
    key(4'd7, 1'b0);

`ifdef LOCK_AUTO_RELOCK_EN
    // Release lands on the timeout cycle; timeout wins
    push(mk(1, 1, 0, 0, 0, 0, 0), 0, "check_r");
    push(mk(2, 1, 1, 0, 1, 0, 0), 4, "open_r");
    bus.correct = 1'b1;
    press(4'd8);
    settle_idle(0);
    push(S_LOCKED, RELOCK, "relock");
    bus.button = 4'd9;
    bus.bstate = 1'b1;
    repeat (15) @(posedge hwclk);
    #1 bus.bstate = 1'b0;
    settle_idle(8);
`else
    do_unlock();
    repeat (1000) @(posedge hwclk);
    #1;
    push(S_LOCKED, 0, "lock_after_hold");
    key(4'd7, 1'b0);
`endif

    // Reset during the first store cycle cuts the pulse short
    do_unlock();
    to_confirm();
    push(mk(6, 2, 0, 0, 0, 0, 0), 0, "check_conf_r");
    push(mk(6, 2, 0, 1, 0, 0, 0), 4, "store_on_r");
    push(S_LOCKED, 1, "store_rst");
    bus.correct = 1'b1;
    press(4'd8);
    cnt = 0;
    while (bus.store !== 1'b1 && cnt < 50) begin
      @(posedge hwclk);
      #1 cnt++;
    end
    rst = 1'b1;
    @(posedge hwclk);
    #1 rst = 1'b0;
    settle_idle(10);

    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL queue_drained: got=%0d pending want=0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
